wave_generator: RTL and testbench

Downstream consumer of the phase accumulator's 18-bit phase word. It samples the phase at a fixed audio sample rate and shapes it into a selectable waveform: sine (quarter-wave LUT), square, triangle or sawtooth. It applies a 4-bit volume and presents signed 12-bit samples on a valid/ready interface to the DAC/PWM stage.

---
 rtl/wave_generator.sv | 212 +++++++++++++++++++++
 tb/tb_wave_generator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_generator.sv
// wave_generator: samples an 18-bit phase word at a fixed audio rate, shapes it into
// sine/square/triangle/sawtooth, scales by volume and offers it on a valid/ready port.
module wave_generator #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int SAMPLE_RATE    = 48_000,
    parameter int LUT_DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] phase,
    input  logic [1:0]  wave_sel,
    input  logic [3:0]  volume,
    input  logic        enable,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [7:0]  overrun_count
);

    localparam int TICK_PERIOD = CPU_CLOCK_FREQ / SAMPLE_RATE;
    localparam int CNT_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);
    localparam int LUT_DEPTH   = 1 << LUT_DEPTH_LOG2;
    localparam int IDX_LSB     = 16 - LUT_DEPTH_LOG2;
    localparam int FRAC        = 30;
    localparam longint PI_Q30  = 64'sd3373259426;

    localparam logic [1:0] SEL_SINE     = 2'd0;
    localparam logic [1:0] SEL_SQUARE   = 2'd1;
    localparam logic [1:0] SEL_TRIANGLE = 2'd2;
    localparam logic [1:0] SEL_SAWTOOTH = 2'd3;

    // Elaboration-time round(2047*sin((i+0.5)*pi/2^(L+1))) via a Q30 Taylor series.
    function automatic logic [10:0] sine_entry(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(2 * idx + 1) * PI_Q30) >>> (LUT_DEPTH_LOG2 + 2);
        x2   = (x * x) >>> FRAC;
        term = x;
        acc  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -(((term * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1)));
            acc  = acc + term;
        end
        acc = (acc * 64'sd2047 + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        acc = (acc > 64'sd2047) ? 64'sd2047 : ((acc < 64'sd0) ? 64'sd0 : acc);
        return acc[10:0];
    endfunction

    logic [10:0] sine_lut_s [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_sine_lut
        localparam logic [10:0] ENTRY = sine_entry(gi);
        assign sine_lut_s[gi] = ENTRY;
    end

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick_s;

    logic             s1_valid_q, s1_valid_d;
    logic [17:0]      s1_phase_q, s1_phase_d;
    logic [1:0]       s1_sel_q,   s1_sel_d;
    logic [3:0]       s1_vol_q,   s1_vol_d;

    logic [1:0]                sine_quad_s;
    logic [LUT_DEPTH_LOG2-1:0] sine_idx_s;
    logic [10:0]               sine_mag_s;
    logic [10:0]               tri_u_s;
    logic [11:0]               raw_s;

    logic             s2_valid_q, s2_valid_d;
    logic [11:0]      s2_raw_q,   s2_raw_d;
    logic [3:0]       s2_vol_q,   s2_vol_d;

    logic signed [15:0] product_s;
    logic signed [15:0] scaled_s;

    logic             out_valid_q, out_valid_d;
    logic [11:0]      out_data_q,  out_data_d;
    logic [7:0]       overrun_q,   overrun_d;
    logic             transfer_s;
    logic             unused_bits_s;

    // Sample-rate tick: counter only runs while enabled, and restarts from 0.
    always_comb begin
        tick_s = enable && (tick_cnt_q == CNT_LAST);
        if (!enable) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        s1_valid_d = tick_s;
        if (tick_s) begin
            s1_phase_d = phase;
            s1_sel_d   = wave_sel;
            s1_vol_d   = volume;
        end else begin
            s1_phase_d = s1_phase_q;
            s1_sel_d   = s1_sel_q;
            s1_vol_d   = s1_vol_q;
        end
    end

    // Waveform shaping; the sine index is mirrored in quadrants 1/3 so the LUT stays quarter-wave.
    always_comb begin
        sine_quad_s = s1_phase_q[17:16];
        if (sine_quad_s[0]) begin
            sine_idx_s = ~s1_phase_q[15:IDX_LSB];
        end else begin
            sine_idx_s = s1_phase_q[15:IDX_LSB];
        end
        sine_mag_s = sine_lut_s[sine_idx_s];
        tri_u_s    = s1_phase_q[17] ? ~s1_phase_q[16:6] : s1_phase_q[16:6];
        case (s1_sel_q)
            SEL_SINE:     raw_s = sine_quad_s[1] ? (12'd0 - {1'b0, sine_mag_s}) : {1'b0, sine_mag_s};
            SEL_SQUARE:   raw_s = s1_phase_q[17] ? 12'h801 : 12'h7FF;
            SEL_TRIANGLE: raw_s = {tri_u_s, 1'b0} - 12'd2047;
            SEL_SAWTOOTH: raw_s = {~s1_phase_q[17], s1_phase_q[16:6]};
            default:      raw_s = 12'd0;
        endcase
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            s2_raw_d = raw_s;
            s2_vol_d = s1_vol_q;
        end else begin
            s2_raw_d = s2_raw_q;
            s2_vol_d = s2_vol_q;
        end
    end

    always_comb begin
        product_s = $signed({{4{s2_raw_q[11]}}, s2_raw_q}) * $signed({12'd0, s2_vol_q});
        scaled_s  = product_s >>> 4;
    end

    // Output slot: a new result replaces the slot only if it is empty or draining this cycle.
    always_comb begin
        transfer_s  = out_valid_q && sample_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        if (s2_valid_q) begin
            if (!out_valid_q || transfer_s) begin
                out_valid_d = 1'b1;
                out_data_d  = scaled_s[11:0];
            end else begin
                overrun_d = (overrun_q == 8'hFF) ? overrun_q : (overrun_q + 8'd1);
            end
        end else if (transfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign unused_bits_s = ^{scaled_s[15:12], s1_phase_q[5:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_phase_q <= 18'd0;
            s1_sel_q   <= 2'd0;
            s1_vol_q   <= 4'd0;
            s2_valid_q <= 1'b0;
            s2_raw_q   <= 12'd0;
            s2_vol_q   <= 4'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_phase_q <= s1_phase_d;
            s1_sel_q   <= s1_sel_d;
            s1_vol_q   <= s1_vol_d;
            s2_valid_q <= s2_valid_d;
            s2_raw_q   <= s2_raw_d;
            s2_vol_q   <= s2_vol_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 12'd0;
            overrun_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_data   = out_data_q;
    assign sample_valid  = out_valid_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator: spec vector table, randomized samples against a
// real-arithmetic reference model, and hand-written timing/backpressure/reset sequences.
module tb_wave_generator;

    localparam int CLK_HZ = 1000;
    localparam int FS     = 100;
    localparam int NV     = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] phase;
    logic [1:0]  wave_sel;
    logic [3:0]  volume;
    logic        enable;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  overrun_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] ph;
        logic [3:0]  vol;
        int          exp;
    } vec_t;

    vec_t vecs [NV];

    wave_generator #(
        .CPU_CLOCK_FREQ(CLK_HZ),
        .SAMPLE_RATE   (FS),
        .LUT_DEPTH_LOG2(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .phase        (phase),
        .wave_sel     (wave_sel),
        .volume       (volume),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: waveform rules evaluated with real trig and integer floor division.
    function automatic int model(input logic [17:0] ph, input logic [1:0] sel, input int vol);
        int  r;
        int  q;
        int  idx;
        int  u;
        int  m;
        int  p;
        real ang;
        r = 0;
        case (sel)
            2'd0: begin
                q   = int'(ph[17:16]);
                idx = int'(ph[15:8]);
                if (q == 1 || q == 3) idx = 255 - idx;
                ang = (real'(idx) + 0.5) * 3.14159265358979 / 512.0;
                m   = $rtoi(2047.0 * $sin(ang) + 0.5);
                r   = (q < 2) ? m : -m;
            end
            2'd1: r = ph[17] ? -2047 : 2047;
            2'd2: begin
                u = int'(ph[16:6]);
                if (ph[17]) u = 2047 - u;
                r = 2 * u - 2047;
            end
            default: r = int'(ph[17:6]) - 2048;
        endcase
        p = r * vol;
        return (p >= 0) ? (p / 16) : -((-p + 15) / 16);
    endfunction

    task automatic wait_sample(input string name, output int data);
        bit got;
        got  = 1'b0;
        data = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sample_valid) begin
                data = int'($signed(sample_data));
                got  = 1'b1;
                break;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL %s: no sample_valid within 40 cycles", name);
        end
    endtask

    initial begin
        int d;
        int held;
        int nhit;
        int first_d;
        int hit [3];
        int nv;
        int stable;
        logic [17:0] rph;
        logic [1:0]  rsel;
        logic [3:0]  rvol;

        rst = 1'b1; enable = 1'b0; sample_ready = 1'b0;
        phase = 18'd0; wave_sel = 2'd0; volume = 4'd0;

        vecs[0]  = '{2'd0, 18'h10000, 4'd15, 1919};
        vecs[1]  = '{2'd0, 18'h30000, 4'd15, -1920};
        vecs[2]  = '{2'd0, 18'h00000, 4'd15, 5};
        vecs[3]  = '{2'd0, 18'h20000, 4'd15, -6};
        vecs[4]  = '{2'd0, 18'h3FFFF, 4'd15, -6};
        vecs[5]  = '{2'd1, 18'h20000, 4'd8,  -1024};
        vecs[6]  = '{2'd1, 18'h00000, 4'd8,  1023};
        vecs[7]  = '{2'd3, 18'h00000, 4'd15, -1920};
        vecs[8]  = '{2'd3, 18'h3FFFF, 4'd15, 1919};
        vecs[9]  = '{2'd2, 18'h20000, 4'd15, 1919};
        vecs[10] = '{2'd2, 18'h00000, 4'd15, -1920};
        vecs[11] = '{2'd0, 18'h12345, 4'd0,  0};
        vecs[12] = '{2'd1, 18'h2ABCD, 4'd0,  0};
        vecs[13] = '{2'd2, 18'h0F0F0, 4'd0,  0};
        vecs[14] = '{2'd3, 18'h3C3C3, 4'd0,  0};
        vecs[15] = '{2'd3, 18'h00000, 4'd1,  -128};

        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(sample_data), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_overrun", int'(overrun_count), 0);

        // First tick 9 edges after release, valid from edge 11, then every 10.
        phase = 18'h10000; wave_sel = 2'd0; volume = 4'd15;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; sample_ready = 1'b1;
        nhit = 0; first_d = 0;
        for (int i = 0; i < 3; i++) hit[i] = -1;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (sample_valid) begin
                if (nhit == 0) first_d = int'($signed(sample_data));
                if (nhit < 3) hit[nhit] = k;
                nhit++;
            end
        end
        check("valid_pulse_count", nhit, 3);
        check("first_valid_edge", hit[0], 11);
        check("second_valid_edge", hit[1], 21);
        check("third_valid_edge", hit[2], 31);
        check("first_sample_data", first_d, 1919);

        wait_sample("sync", d);
        for (int i = 0; i < NV; i++) begin
            phase = vecs[i].ph; wave_sel = vecs[i].sel; volume = vecs[i].vol;
            wait_sample($sformatf("vec%0d", i), d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            rph  = 18'($urandom_range(0, 18'h3FFFF));
            rsel = 2'($urandom_range(0, 3));
            rvol = 4'($urandom_range(0, 15));
            phase = rph; wave_sel = rsel; volume = rvol;
            wait_sample($sformatf("rand%0d", i), d);
            check($sformatf("rand%0d_sel%0d_ph%05h_v%0d", i, rsel, rph, rvol), d, model(rph, rsel, int'(rvol)));
        end
        check("no_overrun_with_ready", int'(overrun_count), 0);

        // Config changed one cycle after a tick: old config for that sample, new for the next.
        @(negedge clk); enable = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        phase = 18'h0C000; wave_sel = 2'd2; volume = 4'd13; enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        phase = 18'h08100; wave_sel = 2'd0; volume = 4'd7;
        wait_sample("cfg_old", d);
        check("cfg_old", d, model(18'h0C000, 2'd2, 13));
        wait_sample("cfg_new", d);
        check("cfg_new", d, model(18'h08100, 2'd0, 7));

        // Enable dropped right after a tick: that sample still emerges, then silence.
        @(negedge clk); enable = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        phase = 18'h2F00F; wave_sel = 2'd3; volume = 4'd9; enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_sample("drop_en_sample", d);
        check("drop_en_sample", d, model(18'h2F00F, 2'd3, 9));
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sample_valid) nv++;
        end
        check("no_ticks_when_disabled", nv, 0);

        // Backpressure: hold first sample, drop later ones, saturate the overrun counter.
        @(negedge clk);
        phase = 18'h1ABC0; wave_sel = 2'd3; volume = 4'd11; enable = 1'b1;
        wait_sample("bp_first", held);
        sample_ready = 1'b0;
        check("bp_first", held, model(18'h1ABC0, 2'd3, 11));
        check("bp_overrun_start", int'(overrun_count), 0);
        phase = 18'h3F000; wave_sel = 2'd0; volume = 4'd15;
        stable = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (int'($signed(sample_data)) != held || !sample_valid) stable = 0;
        end
        check("bp_hold_stable", stable, 1);
        check("bp_overrun_one", int'(overrun_count), 1);
        repeat (2600) @(posedge clk);
        #1;
        check("bp_overrun_saturated", int'(overrun_count), 255);
        check("bp_data_after_saturation", int'($signed(sample_data)), held);
        check("bp_valid_after_saturation", int'(sample_valid), 1);
        @(negedge clk); enable = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); sample_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid_low", int'(sample_valid), 0);
        check("release_data_kept", int'($signed(sample_data)), held);
        check("release_overrun_kept", int'(overrun_count), 255);

        // Asynchronous reset with a sample in flight: outputs clear at once, sample is lost.
        @(negedge clk);
        phase = 18'h00000; wave_sel = 2'd1; volume = 4'd15; enable = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1; enable = 1'b0;
        #1;
        check("async_rst_data", int'(sample_data), 0);
        check("async_rst_valid", int'(sample_valid), 0);
        check("async_rst_overrun", int'(overrun_count), 0);
        @(negedge clk); rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sample_valid) nv++;
        end
        check("inflight_discarded", nv, 0);
        check("data_zero_after_reset", int'(sample_data), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
